// File: rtl/memtest_pkg.sv
// Shared types and constants for the dual-port RAM test sequencer.
package memtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_VF,
      ST_CHK,
      ST_DONE
   } state_t;

   localparam logic [1:0] MODE_ALT   = 2'd0;
   localparam logic [1:0] MODE_A     = 2'd1;
   localparam logic [1:0] MODE_B     = 2'd2;
   localparam logic [1:0] MODE_CROSS = 2'd3;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/memtest_addr_gen.sv
// Address walker: current address, inclusive end-of-range detect and per-address port toggle.
module memtest_addr_gen
   import memtest_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              alt_i,
   input  logic              port_init_i,
   input  logic [ADDR_W-1:0] lo_i,
   input  logic [ADDR_W-1:0] hi_i,
   output logic [ADDR_W-1:0] cur_o,
   output logic              last_o,
   output logic              port_o
);

   logic [ADDR_W-1:0] cur_q;
   logic [ADDR_W-1:0] hi_q;
   logic              port_q;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q  <= '0;
         hi_q   <= '0;
         port_q <= PORT_A;
      end else if (load_i) begin
         cur_q  <= lo_i;
         hi_q   <= hi_i;
         port_q <= port_init_i;
      end else if (step_i) begin
         cur_q <= cur_q + ADDR_W'(1);
         if (alt_i) port_q <= ~port_q;
      end
   end

   // Compared before any increment, so a range ending at all-ones stops without wrapping.
   assign last_o = (cur_q == hi_q);
   assign cur_o  = cur_q;
   assign port_o = port_q;

endmodule

// File: rtl/memtest_seq.sv
// Read-modify-write-verify sweep over a run-time address range of a true dual-port RAM,
// with per-run port selection, saturating mismatch count and first-failure capture.
module memtest_seq
   import memtest_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] addr_lo,
   input  logic [ADDR_W-1:0] addr_hi,
   input  logic [DATA_W-1:0] q_a,
   input  logic [DATA_W-1:0] q_b,
   output logic              we_a,
   output logic              we_b,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic              selectout,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   state_t            state_q;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] exp_q;
   logic [ERR_W-1:0]  err_q;
   logic [ADDR_W-1:0] first_q;
   logic              pass_q;
   logic              done_q;
   logic              busy_q;
   logic              sel_hold_q;

   logic [ADDR_W-1:0] cur;
   logic              last;
   logic              port;
   logic              accept;
   logic              wport;
   logic              vport;
   logic [DATA_W-1:0] wdata;
   logic              mismatch;
   logic [ERR_W-1:0]  err_d;
   logic              sel_c;

   assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

   memtest_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept),
      .step_i      (state_q == ST_CHK && !last),
      .alt_i       (mode_q == MODE_ALT),
      .port_init_i ((mode == MODE_B) ? PORT_B : PORT_A),
      .lo_i        (addr_lo),
      .hi_i        (addr_hi),
      .cur_o       (cur),
      .last_o      (last),
      .port_o      (port)
   );

   // Cross mode writes through A and proves the data through B.
   assign wport    = (mode_q == MODE_CROSS) ? PORT_A : port;
   assign vport    = (mode_q == MODE_CROSS) ? PORT_B : port;
   assign wdata    = (wport ? q_b : q_a) + DATA_W'(cur);
   assign mismatch = (vport ? q_b : q_a) != exp_q;
   assign err_d    = !mismatch ? err_q : ((err_q == '1) ? err_q : err_q + ERR_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_ALT;
         exp_q      <= '0;
         err_q      <= '0;
         first_q    <= '0;
         pass_q     <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         sel_hold_q <= 1'b0;
      end else begin
         sel_hold_q <= sel_c;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  mode_q  <= mode;
                  err_q   <= '0;
                  first_q <= '0;
                  if (addr_lo > addr_hi) begin
                     state_q <= ST_DONE;
                     pass_q  <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RD;
                     pass_q  <= 1'b0;
                     done_q  <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_RD: state_q <= ST_WR;
            ST_WR: begin
               exp_q   <= wdata;
               state_q <= ST_VF;
            end
            ST_VF: state_q <= ST_CHK;
            ST_CHK: begin
               err_q <= err_d;
               if (mismatch && err_q == '0) first_q <= cur;
               if (last) begin
                  state_q <= ST_DONE;
                  pass_q  <= (err_d == '0);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= ST_RD;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      we_a   = 1'b0;
      we_b   = 1'b0;
      data_a = '0;
      data_b = '0;
      addr_a = '0;
      addr_b = '0;
      sel_c  = 1'b0;
      case (state_q)
         ST_RD: begin
            sel_c = wport;
            if (wport) addr_b = cur;
            else       addr_a = cur;
         end
         ST_WR: begin
            sel_c = wport;
            if (wport) begin
               we_b   = 1'b1;
               addr_b = cur;
               data_b = wdata;
            end else begin
               we_a   = 1'b1;
               addr_a = cur;
               data_a = wdata;
            end
         end
         ST_VF: begin
            sel_c = vport;
            if (vport) addr_b = cur;
            else       addr_a = cur;
         end
         ST_CHK:  sel_c = vport;
         ST_DONE: sel_c = sel_hold_q;
         default: sel_c = 1'b0;
      endcase
   end

   assign selectout      = sel_c;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;

endmodule

// File: tb/tb_memtest_seq.sv
// Self-checking bench: behavioural RAM with fault injection and a per-address schedule model.
module tb_memtest_seq;

   localparam int DW = 16;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic [AW-1:0] addr_lo, addr_hi;
   logic [DW-1:0] q_a, q_b;
   logic          we_a, we_b;
   logic [DW-1:0] data_a, data_b;
   logic [AW-1:0] addr_a, addr_b;
   logic          selectout, busy, done, pass;
   logic [7:0]    err_count;
   logic [AW-1:0] first_err_addr;

   logic          start2;
   logic [1:0]    mode2;
   logic [AW-1:0] lo2, hi2;
   logic [DW-1:0] q_a2, q_b2;
   logic          we_a2, we_b2;
   logic [DW-1:0] data_a2, data_b2;
   logic [AW-1:0] addr_a2, addr_b2;
   logic          sel2, busy2, done2, pass2;
   logic [1:0]    err2;
   logic [AW-1:0] first2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   memtest_seq #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .addr_lo(addr_lo), .addr_hi(addr_hi),
      .q_a(q_a), .q_b(q_b), .we_a(we_a), .we_b(we_b), .data_a(data_a), .data_b(data_b),
      .addr_a(addr_a), .addr_b(addr_b), .selectout(selectout), .busy(busy), .done(done),
      .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
   );

   memtest_seq #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode2), .addr_lo(lo2), .addr_hi(hi2),
      .q_a(q_a2), .q_b(q_b2), .we_a(we_a2), .we_b(we_b2), .data_a(data_a2), .data_b(data_b2),
      .addr_a(addr_a2), .addr_b(addr_b2), .selectout(sel2), .busy(busy2), .done(done2),
      .pass(pass2), .err_count(err2), .first_err_addr(first2)
   );

   // RAM models: 1-cycle read latency; faults are applied on the read path
   logic [DW-1:0] mem     [0:1023];
   logic [DW-1:0] mem2    [0:1023];
   logic [DW-1:0] ref_pre [0:1023];
   int            fault_kind = 0;
   logic [AW-1:0] fault_addr = '0;
   logic          fill_req = 1'b0;

   function automatic logic [DW-1:0] rd_f(input logic [AW-1:0] a, input logic [DW-1:0] v);
      if (fault_kind == 1 && a == fault_addr) return {v[DW-1:1], 1'b0};
      return v;
   endfunction

   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < 1024; i++) begin
            mem[i]  <= ref_pre[i];
            mem2[i] <= '0;
         end
      end else begin
         if (we_a)  mem[addr_a]   <= data_a;
         if (we_b)  mem[addr_b]   <= data_b;
         if (we_a2) mem2[addr_a2] <= data_a2;
         if (we_b2) mem2[addr_b2] <= data_b2;
      end
      q_a  <= rd_f(addr_a, mem[addr_a]);
      q_b  <= rd_f(addr_b, mem[addr_b]);
      q_a2 <= mem2[addr_a2] ^ DW'(1);
      q_b2 <= mem2[addr_b2] ^ DW'(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model of one run
   int   m_mode, m_lo, m_hi, m_n, e_err, e_first;
   logic e_pass;
   logic sel_hold_m = 1'b0;
   bit   tracking = 1'b0;
   int   mc = 0;

   function automatic logic [DW-1:0] wval(input logic [AW-1:0] a);
      return rd_f(a, ref_pre[a]) + DW'(a);
   endfunction

   function automatic logic [63:0] act_vec();
      return {7'd0, we_a, we_b, data_a, data_b, addr_a, addr_b, selectout, busy, done};
   endfunction

   function automatic logic [63:0] exp_vec(input int c);
      logic wea, web, sel, bsy, dn, pw, pv;
      logic [DW-1:0] da, db;
      logic [AW-1:0] aa, ab, a;
      int k, ph;
      wea = 1'b0; web = 1'b0; da = '0; db = '0; aa = '0; ab = '0;
      sel = sel_hold_m; bsy = 1'b0; dn = 1'b0;
      if (c <= 4 * m_n) begin
         k  = (c - 1) / 4;
         ph = (c - 1) % 4;
         a  = AW'(m_lo + k);
         bsy = 1'b1;
         case (m_mode)
            0:       pw = (k % 2) == 1;
            2:       pw = 1'b1;
            default: pw = 1'b0;
         endcase
         pv = (m_mode == 3) ? 1'b1 : pw;
         case (ph)
            0: begin sel = pw; if (pw) ab = a; else aa = a; end
            1: begin
               sel = pw;
               if (pw) begin web = 1'b1; ab = a; db = wval(a); end
               else    begin wea = 1'b1; aa = a; da = wval(a); end
            end
            2: begin sel = pv; if (pv) ab = a; else aa = a; end
            default: sel = pv;
         endcase
      end else begin
         dn = 1'b1;
      end
      return {7'd0, wea, web, da, db, aa, ab, sel, bsy, dn};
   endfunction

   // Compare process: checks every cycle of a tracked run against the model
   initial forever begin
      logic [63:0] ev;
      @(negedge clk);
      if (tracking) begin
         mc++;
         ev = exp_vec(mc);
         sel_hold_m = ev[2];
         check($sformatf("cycle%0d", mc), act_vec(), ev);
         if (mc == 4 * m_n + 1) begin
            check("err_count", err_count, e_err);
            check("first_err_addr", first_err_addr, e_first);
            check("pass", pass, e_pass);
            tracking = 1'b0;
         end
      end
   end

   task automatic fill();
      @(posedge clk); #1 fill_req = 1'b1;
      @(posedge clk); #1 fill_req = 1'b0;
   endtask

   task automatic run(input int md, input int lo, input int hi, input bit glitch,
                      input int rst_at, output int cnt);
      logic [DW-1:0] w;
      m_mode = md; m_lo = lo; m_hi = hi;
      m_n = (lo > hi) ? 0 : hi - lo + 1;
      e_err = 0; e_first = 0;
      for (int a = lo; a <= hi; a++) begin
         w = wval(AW'(a));
         if (rd_f(AW'(a), w) != w) begin
            if (e_err == 0) e_first = a;
            if (e_err < 255) e_err++;
         end
      end
      e_pass = (e_err == 0);
      @(posedge clk); #1;
      start = 1'b1; mode = 2'(md); addr_lo = AW'(lo); addr_hi = AW'(hi);
      @(posedge clk); #1;
      start = 1'b0; mode = 2'($urandom); addr_lo = AW'($urandom); addr_hi = AW'($urandom);
      mc = 0; tracking = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (glitch && cnt == 6) begin
            start = 1'b1; mode = 2'($urandom); addr_lo = '0; addr_hi = '0;
         end
         if (glitch && cnt == 7) start = 1'b0;
         if (rst_at != 0 && cnt == rst_at) begin
            check("wr_before_rst", {we_a, addr_a}, {1'b1, 10'd2});
            rst = 1'b1;
            tracking = 1'b0;
            break;
         end
      end while (!done && cnt < 4 * m_n + 20);
      if (rst_at != 0) begin
         @(posedge clk); #1 rst = 1'b0;
         sel_hold_m = 1'b0;
         @(negedge clk);
         check("after_rst_outs", act_vec(), 64'd0);
         check("after_rst_status", {pass, err_count, first_err_addr}, 0);
      end else begin
         @(posedge clk); #1;
         if (tracking) begin
            check("run_timeout", 1, 0);
            tracking = 1'b0;
         end
         check("done_held", done, 1);
      end
   endtask

   initial begin
      int cnt, lo, hi, len, md;
      rst = 1'b1; start = 1'b0; mode = '0; addr_lo = '0; addr_hi = '0;
      start2 = 1'b0; mode2 = '0; lo2 = '0; hi2 = '0;
      for (int i = 0; i < 1024; i++) ref_pre[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outs", act_vec(), 64'd0);
      check("reset_status", {pass, err_count, first_err_addr}, 0);
      fill();

      // Zero-filled RAM, alternate ports over 0..3
      run(0, 0, 3, 0, 0, cnt);
      check("t1_done_cycle", cnt, 17);
      check("t1_mem", {mem[1], mem[3]}, {16'h0001, 16'h0003});
      check("t1_pass", {pass, err_count}, {1'b1, 8'd0});

      // Cross mode at top of address space, RAM preloaded 0x1000
      for (int i = 0; i < 1024; i++) ref_pre[i] = 16'h1000;
      fill();
      run(3, 10'h3FE, 10'h3FF, 0, 0, cnt);
      check("t2_done_cycle", cnt, 9);
      check("t2_mem", {mem[10'h3FE], mem[10'h3FF]}, {16'h13FE, 16'h13FF});
      check("t2_sel_hold", selectout, 1);

      // Stuck-at-0 bit 0 on address 5
      for (int i = 0; i < 1024; i++) ref_pre[i] = '0;
      fault_kind = 1; fault_addr = 10'h005;
      fill();
      run(1, 4, 6, 0, 0, cnt);
      check("t3_err", {pass, err_count, first_err_addr}, {1'b0, 8'd1, 10'h005});
      fault_kind = 0;

      // Empty range
      run(0, 5, 2, 0, 0, cnt);
      check("t4_done_cycle", cnt, 1);
      check("t4_pass", pass, 1);

      // Reset during WR of address 2, then a clean rerun, then an ignored mid-run start
      fill();
      run(0, 0, 7, 0, 10, cnt);
      fill();
      run(0, 0, 7, 0, 0, cnt);
      check("t5_done_cycle", cnt, 33);
      run(2, 100, 104, 1, 0, cnt);
      check("t6_done_cycle", cnt, 21);

      // Randomized runs
      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < 1024; i++) ref_pre[i] = DW'($urandom);
         md  = $urandom_range(0, 3);
         len = $urandom_range(0, 9);
         if (len == 0) begin
            lo = $urandom_range(1, 1023);
            hi = lo - 1;
         end else begin
            lo = $urandom_range(0, 1023);
            hi = (lo + len - 1 > 1023) ? 1023 : lo + len - 1;
         end
         fault_kind = $urandom_range(0, 1);
         fault_addr = AW'(lo + $urandom_range(0, len));
         fill();
         run(md, lo, hi, r[0], 0, cnt);
         check($sformatf("rand%0d_done_cycle", r), cnt, (lo > hi) ? 1 : 4 * (hi - lo + 1) + 1);
      end
      fault_kind = 0;

      // Saturating counter: 2-bit instance, every verify read corrupted
      fill();
      @(posedge clk); #1;
      start2 = 1'b1; mode2 = 2'd1; lo2 = '0; hi2 = 10'd7;
      @(posedge clk); #1 start2 = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!done2 && cnt < 60);
      check("sat_done_cycle", cnt, 33);
      check("sat_status", {done2, busy2, pass2, err2, first2}, {3'b100, 2'b11, 10'd0});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
